mby_wm_pkt_assembler: RTL and testbench

- Stage directly upstream of the white-model packet push DPI call.
- Collects a word-serial egress packet stream (8 bytes per beat) for one packet at a time into a local buffer.
- Presents each complete packet (port, byte length, random-access byte-word reads) to the testbench driver, which reads it out and calls the push function.
- Also filters malformed framing and counts accepted and dropped packets.

---
 rtl/mby_wm_pkt_pkg.sv | 35 +++
 rtl/mby_wm_pkt_assembler_if.sv | 46 ++++
 rtl/mby_wm_pkt_buf.sv | 42 ++++
 rtl/mby_wm_pkt_assembler.sv | 170 +++++++++++++++++
 tb/tb_mby_wm_pkt_assembler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mby_wm_pkt_pkg.sv
// rtl/mby_wm_pkt_pkg.sv - shared types and constants for the white-model packet assembler
//
// Contents:
//   state_e     assembler FSM states
//   BEAT_BYTES  bytes carried per input beat
//   beat_t      one captured input beat
//   desc_t      descriptor of the packet held for the consumer
package mby_wm_pkt_pkg;

  localparam int BEAT_BYTES        = 8;
  localparam int MAX_PKT_BYTES_DEF = 2048;
  localparam int PORT_W_DEF        = 6;
  localparam int LEN_W_DEF         = $clog2(MAX_PKT_BYTES_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  typedef struct packed {
    logic [63:0]           data;
    logic                  sop;
    logic                  eop;
    logic [2:0]            eop_bytes;
    logic [PORT_W_DEF-1:0] port;
  } beat_t;

  typedef struct packed {
    logic [PORT_W_DEF-1:0] port;
    logic [LEN_W_DEF-1:0]  len;
  } desc_t;

endpackage

// File: rtl/mby_wm_pkt_assembler_if.sv
// rtl/mby_wm_pkt_assembler_if.sv - beat stream, held-packet and buffer read signals
//
// Signals:
//   in_*          word-serial packet stream into the assembler
//   pkt_valid/_ready/_port/_len  held-packet handshake and descriptor
//   rd_idx/rd_data               random-access word read of the held packet
// Modports:
//   master  the driver/consumer side (testbench)
//   slave   the assembler
interface mby_wm_pkt_assembler_if
  import mby_wm_pkt_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WIDX_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              in_sop;
  logic              in_eop;
  logic [2:0]        in_eop_bytes;
  logic [PORT_W-1:0] in_port;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [PORT_W-1:0] pkt_port;
  logic [LEN_W-1:0]  pkt_len;

  logic [WIDX_W-1:0] rd_idx;
  logic [63:0]       rd_data;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_eop_bytes, in_port,
    output pkt_ready, rd_idx,
    input  in_ready, pkt_valid, pkt_port, pkt_len, rd_data
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_eop_bytes, in_port,
    input  pkt_ready, rd_idx,
    output in_ready, pkt_valid, pkt_port, pkt_len, rd_data
  );

endinterface

// File: rtl/mby_wm_pkt_buf.sv
// rtl/mby_wm_pkt_buf.sv - packet word buffer, one sync write port, one registered read port
//
// Ports:
//   clk, rst            clock, async active-high reset (read register only)
//   wr_en/wr_idx/wr_data  synchronous word write
//   rd_idx/rd_data        read, data registered one cycle after rd_idx
// A same-cycle read of the word being written returns the previous contents.
module mby_wm_pkt_buf
  import mby_wm_pkt_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int WIDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDX_W-1:0] wr_idx,
  input  logic [63:0]       wr_data,
  input  logic [WIDX_W-1:0] rd_idx,
  output logic [63:0]       rd_data
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mby_wm_pkt_assembler.sv
// rtl/mby_wm_pkt_assembler.sv - assembles one egress packet at a time for the white-model push
//
// Ports:
//   clk, rst   clock, async active-high reset
//   io         slave side of mby_wm_pkt_assembler_if (beat stream in,
//              held-packet descriptor and buffer reads out)
//   pkt_cnt    packets delivered to the consumer (wraps)
//   drop_cnt   malformed or oversize packets dropped (wraps)
module mby_wm_pkt_assembler
  import mby_wm_pkt_pkg::*;
#(
  parameter int MAX_PKT_BYTES = MAX_PKT_BYTES_DEF,
  parameter int PORT_W        = PORT_W_DEF,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  mby_wm_pkt_assembler_if.slave   io,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int LEN_W  = $clog2(MAX_PKT_BYTES + 1);
  localparam int WIDX_W = $clog2(MAX_PKT_BYTES / BEAT_BYTES);
  localparam int DEPTH  = MAX_PKT_BYTES / BEAT_BYTES;
  localparam logic [LEN_W:0] MAX_EXT = (LEN_W + 1)'(MAX_PKT_BYTES);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [PORT_W-1:0] port_q, port_d;
  desc_t             desc_q, desc_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              pkt_valid_q, pkt_valid_d;

  beat_t             beat;
  logic              accept;
  logic [LEN_W:0]    next_cnt_ext;
  logic [LEN_W:0]    eop_len_ext;
  logic              wr_en;
  logic [WIDX_W-1:0] wr_idx;

  always_comb begin
    beat.data      = io.in_data;
    beat.sop       = io.in_sop;
    beat.eop       = io.in_eop;
    beat.eop_bytes = io.in_eop_bytes;
    beat.port      = io.in_port;
  end

  assign accept = io.in_valid && in_ready_q;

  // One bit wider than the length so oversize sums are not lost to wrap.
  assign next_cnt_ext = {1'b0, byte_cnt_q} + (LEN_W + 1)'(BEAT_BYTES);
  assign eop_len_ext  = {1'b0, byte_cnt_q} + (LEN_W + 1)'(beat.eop_bytes)
                      + (LEN_W + 1)'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    port_d     = port_q;
    desc_d     = desc_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    wr_idx     = byte_cnt_q[3 +: WIDX_W];

    if (state_q == ST_HOLD) begin
      if (io.pkt_ready) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        state_d   = ST_IDLE;
      end
    end else if (accept) begin
      if (beat.sop) begin
        // A sop abandons any packet in progress; only a live FILL counts as a drop.
        if (state_q == ST_FILL) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        wr_en  = 1'b1;
        wr_idx = '0;
        if (beat.eop) begin
          desc_d.port = beat.port;
          desc_d.len  = LEN_W'(beat.eop_bytes) + LEN_W'(1);
          state_d     = ST_HOLD;
        end else begin
          port_d     = beat.port;
          byte_cnt_d = LEN_W'(BEAT_BYTES);
          state_d    = ST_FILL;
        end
      end else begin
        case (state_q)
          ST_FILL: begin
            if (!beat.eop) begin
              if (next_cnt_ext > MAX_EXT) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
                state_d    = ST_DROP;
              end else begin
                wr_en      = 1'b1;
                byte_cnt_d = next_cnt_ext[LEN_W-1:0];
              end
            end else if (eop_len_ext > MAX_EXT) begin
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
              state_d    = ST_IDLE;
            end else begin
              wr_en       = 1'b1;
              desc_d.port = port_q;
              desc_d.len  = eop_len_ext[LEN_W-1:0];
              state_d     = ST_HOLD;
            end
          end
          ST_DROP: begin
            if (beat.eop) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            // Stray non-sop beat in IDLE: discarded silently.
          end
        endcase
      end
    end

    in_ready_d  = (state_d != ST_HOLD);
    pkt_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      port_q      <= '0;
      desc_q      <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      port_q      <= port_d;
      desc_q      <= desc_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      in_ready_q  <= in_ready_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  mby_wm_pkt_buf #(
    .DEPTH  (DEPTH),
    .WIDX_W (WIDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (beat.data),
    .rd_idx  (io.rd_idx),
    .rd_data (io.rd_data)
  );

  assign io.in_ready  = in_ready_q;
  assign io.pkt_valid = pkt_valid_q;
  assign io.pkt_port  = desc_q.port;
  assign io.pkt_len   = desc_q.len;
  assign pkt_cnt      = pkt_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_mby_wm_pkt_assembler.sv
// tb/tb_mby_wm_pkt_assembler.sv - directed self-checking bench for mby_wm_pkt_assembler
module tb_mby_wm_pkt_assembler;

  logic        clk;
  logic        rst;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;
  int          total;
  int          bad;

  mby_wm_pkt_assembler_if #(.PORT_W(6), .LEN_W(12), .WIDX_W(8)) io ();

  mby_wm_pkt_assembler #(
    .MAX_PKT_BYTES (2048),
    .PORT_W        (6),
    .CNT_W         (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (io),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic s, input logic e,
                      input logic [2:0] eb, input logic [5:0] p);
    io.in_valid     = 1'b1;
    io.in_data      = d;
    io.in_sop       = s;
    io.in_eop       = e;
    io.in_eop_bytes = eb;
    io.in_port      = p;
    step();
    io.in_valid     = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] idx, input logic [63:0] exp, input string tag);
    io.rd_idx = idx;
    step();
    check(tag, io.rd_data, exp);
  endtask

  task automatic pop();
    io.pkt_ready = 1'b1;
    step();
    io.pkt_ready = 1'b0;
  endtask

  function automatic logic [63:0] long_word(input int i);
    return {32'hF00D_0000, 32'(i)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    io.in_valid = 1'b0; io.in_data = '0; io.in_sop = 1'b0; io.in_eop = 1'b0;
    io.in_eop_bytes = '0; io.in_port = '0; io.pkt_ready = 1'b0; io.rd_idx = '0;

    // Reset values
    step(); step();
    check("rst_pkt_valid", io.pkt_valid, 0);
    check("rst_pkt_port", io.pkt_port, 0);
    check("rst_pkt_len", io.pkt_len, 0);
    check("rst_rd_data", io.rd_data, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", io.in_ready, 1);

    // 3-beat packet, port 5, eop_bytes=3 -> len 20
    beat(64'h1111_0000_0000_0000, 1, 0, 0, 6'd5);
    beat(64'h2222_0000_0000_0001, 0, 0, 0, 6'd7);
    check("t1_valid_before_eop", io.pkt_valid, 0);
    beat(64'h3333_0000_0000_0002, 0, 1, 3, 6'd0);
    check("t1_valid", io.pkt_valid, 1);
    check("t1_len", io.pkt_len, 20);
    check("t1_port", io.pkt_port, 5);
    check("t1_in_ready_hold", io.in_ready, 0);
    read_word(0, 64'h1111_0000_0000_0000, "t1_rd0");
    read_word(1, 64'h2222_0000_0000_0001, "t1_rd1");
    read_word(2, 64'h3333_0000_0000_0002, "t1_rd2");
    pop();
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_valid_after_pop", io.pkt_valid, 0);
    check("t1_in_ready_after_pop", io.in_ready, 1);

    // Single-beat packet held 10 cycles while another beat is offered
    beat(64'hAAAA_BBBB_CCCC_DDDD, 1, 1, 0, 6'd9);
    check("t2_valid", io.pkt_valid, 1);
    check("t2_len", io.pkt_len, 1);
    io.in_valid = 1'b1; io.in_data = 64'hDEAD_DEAD_DEAD_DEAD; io.in_sop = 1'b1;
    io.in_eop = 1'b1; io.in_eop_bytes = 3'd7; io.in_port = 6'd3;
    repeat (10) step();
    check("t2_in_ready_held", io.in_ready, 0);
    check("t2_port_stable", io.pkt_port, 9);
    check("t2_len_stable", io.pkt_len, 1);
    io.in_valid = 1'b0;
    read_word(0, 64'hAAAA_BBBB_CCCC_DDDD, "t2_rd0_not_overwritten");
    pop();
    check("t2_pkt_cnt", pkt_cnt, 2);
    check("t2_valid_after_pop", io.pkt_valid, 0);

    // 258 beats: 257th non-eop beat overflows -> DROP, eop beat returns to IDLE
    beat(long_word(0), 1, 0, 0, 6'd1);
    for (int i = 1; i < 256; i++) beat(long_word(i), 0, 0, 0, 6'd0);
    check("t3_drop_at_max", drop_cnt, 0);
    beat(long_word(256), 0, 0, 0, 6'd0);
    check("t3_drop_overflow", drop_cnt, 1);
    beat(long_word(257), 0, 1, 7, 6'd0);
    check("t3_no_valid", io.pkt_valid, 0);
    check("t3_in_ready", io.in_ready, 1);
    beat(64'h0123_4567_89AB_CDEF, 1, 0, 0, 6'd2);
    beat(64'hFEDC_BA98_7654_3210, 0, 1, 7, 6'd0);
    check("t3_next_valid", io.pkt_valid, 1);
    check("t3_next_len", io.pkt_len, 16);
    check("t3_next_port", io.pkt_port, 2);
    read_word(1, 64'hFEDC_BA98_7654_3210, "t3_next_rd1");
    pop();
    check("t3_pkt_cnt", pkt_cnt, 3);

    // Exactly MAX_PKT_BYTES is accepted
    beat(long_word(0), 1, 0, 0, 6'd4);
    for (int i = 1; i < 255; i++) beat(long_word(i), 0, 0, 0, 6'd0);
    beat(long_word(255), 0, 1, 7, 6'd0);
    check("t3b_valid", io.pkt_valid, 1);
    check("t3b_len", io.pkt_len, 2048);
    read_word(8'd255, long_word(255), "t3b_rd255");
    read_word(8'd100, long_word(100), "t3b_rd100");
    pop();
    check("t3b_pkt_cnt", pkt_cnt, 4);
    check("t3b_drop_cnt", drop_cnt, 1);

    // One byte over MAX on the eop beat -> dropped straight to IDLE
    beat(long_word(0), 1, 0, 0, 6'd4);
    for (int i = 1; i < 256; i++) beat(long_word(i), 0, 0, 0, 6'd0);
    beat(long_word(256), 0, 1, 0, 6'd0);
    check("t3c_drop_cnt", drop_cnt, 2);
    check("t3c_no_valid", io.pkt_valid, 0);
    check("t3c_in_ready", io.in_ready, 1);

    // sop while in DROP starts a new packet with no extra drop
    beat(long_word(0), 1, 0, 0, 6'd4);
    for (int i = 1; i < 257; i++) beat(long_word(i), 0, 0, 0, 6'd0);
    check("t3d_drop_cnt", drop_cnt, 3);
    beat(64'h5555_6666_7777_8888, 1, 1, 2, 6'd12);
    check("t3d_valid", io.pkt_valid, 1);
    check("t3d_len", io.pkt_len, 3);
    check("t3d_port", io.pkt_port, 12);
    check("t3d_drop_unchanged", drop_cnt, 3);
    pop();
    check("t3d_pkt_cnt", pkt_cnt, 5);

    // sop in FILL after 4 beats
    beat(64'h1, 1, 0, 0, 6'd8);
    beat(64'h2, 0, 0, 0, 6'd0);
    beat(64'h3, 0, 0, 0, 6'd0);
    beat(64'h4, 0, 0, 0, 6'd0);
    beat(64'h9999_0000_1234_5678, 1, 1, 7, 6'd11);
    check("t4_drop_cnt", drop_cnt, 4);
    check("t4_valid", io.pkt_valid, 1);
    check("t4_len", io.pkt_len, 8);
    check("t4_port", io.pkt_port, 11);
    read_word(0, 64'h9999_0000_1234_5678, "t4_rd0");
    pop();
    check("t4_pkt_cnt", pkt_cnt, 6);

    // Stray non-sop beats in IDLE
    beat(64'h77, 0, 0, 0, 6'd1);
    beat(64'h78, 0, 1, 5, 6'd1);
    beat(64'h79, 0, 0, 0, 6'd1);
    check("t5_stray_valid", io.pkt_valid, 0);
    check("t5_stray_pkt_cnt", pkt_cnt, 6);
    check("t5_stray_drop_cnt", drop_cnt, 4);
    check("t5_stray_in_ready", io.in_ready, 1);

    // Reset asserted mid-FILL
    beat(64'hA0, 1, 0, 0, 6'd20);
    beat(64'hA1, 0, 0, 0, 6'd0);
    rst = 1'b1;
    #1;
    check("t5_rst_pkt_cnt", pkt_cnt, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    check("t5_rst_valid", io.pkt_valid, 0);
    step();
    rst = 1'b0;
    step();
    check("t5_rel_in_ready", io.in_ready, 1);
    beat(64'hA2, 0, 1, 1, 6'd0);
    check("t5_partial_gone", io.pkt_valid, 0);
    check("t5_partial_no_drop", drop_cnt, 0);
    beat(64'hB0, 1, 1, 4, 6'd33);
    check("t5_after_rst_valid", io.pkt_valid, 1);
    check("t5_after_rst_len", io.pkt_len, 5);
    pop();
    check("t5_after_rst_pkt_cnt", pkt_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
